// File: rtl/register_file_pkg.sv
// Shared constants and helpers for the architectural register file.
package register_file_pkg;

    // Default RoB index width; must track the RoB's own parameter.
    localparam int ROB_WIDTH_DEFAULT = 3;

    // RV32I architectural register count and the matching address width.
    localparam int NUM_ARCH_REGS = 32;
    localparam int REG_ADDR_W    = 5;

    // Data word width.
    localparam int XLEN = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [XLEN-1:0]       word_t;

    // Hard-wired zero register.
    localparam reg_addr_t REG_ZERO = '0;

    // True when a rename or commit to this register must change state.
    function automatic logic is_writable(input reg_addr_t addr);
        return addr != REG_ZERO;
    endfunction

endpackage : register_file_pkg

// File: rtl/register_file_rf_read_port.sv
// One Dispatcher operand read port: selects the stored busy/tag/value for the
// requested register and overlays the same-cycle commit bypass and flush.
module rf_read_port
    import register_file_pkg::*;
#(
    parameter int RoB_WIDTH = ROB_WIDTH_DEFAULT,
    parameter int REG_COUNT = NUM_ARCH_REGS
) (
    // Requested source register
    input  logic [REG_ADDR_W-1:0]                rs_reg,
    // Current architectural state
    input  logic [REG_COUNT-1:0]                 busy_q,
    input  logic [REG_COUNT-1:0][RoB_WIDTH-1:0]  tag_q,
    input  logic [REG_COUNT-1:0][XLEN-1:0]       value_q,
    // Same-cycle commit and flush, already qualified by rdy_in
    input  logic                                 commit_en,
    input  logic [REG_ADDR_W-1:0]                commit_reg,
    input  logic [RoB_WIDTH-1:0]                 commit_index,
    input  logic [XLEN-1:0]                      commit_data,
    input  logic                                 flush_en,
    // Forwarded operand
    output logic                                 rs_busy,
    output logic [RoB_WIDTH-1:0]                 rs_tag,
    output logic [XLEN-1:0]                      rs_value
);

    logic                 sel_busy;
    logic [RoB_WIDTH-1:0] sel_tag;
    logic [XLEN-1:0]      sel_value;
    logic                 bypass_hit;

    // Stored-state lookup for the requested register.
    always_comb begin
        sel_busy  = busy_q[rs_reg];
        sel_tag   = tag_q[rs_reg];
        sel_value = value_q[rs_reg];
    end

    // The committing entry is the one this register is waiting on, so the
    // operand can be taken straight from the commit bus this cycle.
    always_comb begin
        bypass_hit = commit_en && (commit_reg == rs_reg) && sel_busy &&
                     (sel_tag == commit_index);
    end

    // Output mux: x0 override first, then bypass, then flush clearing busy.
    always_comb begin
        // NOTE: every output gets a default before any branch so no path
        // leaves it unassigned, which would otherwise infer a latch.
        rs_busy  = sel_busy;
        rs_tag   = sel_tag;
        rs_value = sel_value;
        if (!is_writable(rs_reg)) begin
            rs_busy  = 1'b0;
            rs_tag   = '0;
            rs_value = '0;
        end else begin
            if (bypass_hit) begin
                rs_busy  = 1'b0;
                rs_value = commit_data;
            end
            if (flush_en) begin
                rs_busy = 1'b0;
            end
        end
    end

endmodule : rf_read_port

// File: rtl/register_file.sv
// Architectural register file with per-register rename state (busy + RoB tag).
// Holds committed values, serves two combinational Dispatcher read ports and
// applies flush > commit > rename updates on the rising clock edge.
module register_file
    import register_file_pkg::*;
#(
    parameter int RoB_WIDTH = ROB_WIDTH_DEFAULT,
    parameter int REG_COUNT = NUM_ARCH_REGS
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    // Dispatcher source operands
    input  logic [REG_ADDR_W-1:0] rs1_reg,
    output logic                  rs1_busy,
    output logic [RoB_WIDTH-1:0]  rs1_tag,
    output logic [XLEN-1:0]       rs1_value,
    input  logic [REG_ADDR_W-1:0] rs2_reg,
    output logic                  rs2_busy,
    output logic [RoB_WIDTH-1:0]  rs2_tag,
    output logic [XLEN-1:0]       rs2_value,
    // Dispatcher destination rename
    input  logic                  rename_en,
    input  logic [REG_ADDR_W-1:0] rename_reg,
    input  logic [RoB_WIDTH-1:0]  rename_index,
    // RoB commit port
    input  logic                  RF_update_en,
    input  logic [REG_ADDR_W-1:0] RF_update_reg,
    input  logic [RoB_WIDTH-1:0]  RF_update_index,
    input  logic [XLEN-1:0]       RF_update_data,
    // RoB misprediction flush
    input  logic                  flush_signal
);

    // Architectural state
    logic [REG_COUNT-1:0][XLEN-1:0]      value_q, value_d;
    logic [REG_COUNT-1:0]                busy_q,  busy_d;
    logic [REG_COUNT-1:0][RoB_WIDTH-1:0] tag_q,   tag_d;

    // Strobes qualified by the global ready; with rdy_in low nothing is seen.
    logic commit_en;
    logic commit_live;
    logic flush_en;
    logic rename_live;

    // Qualify incoming strobes; x0 targets never change state.
    always_comb begin
        commit_en   = rdy_in && RF_update_en;
        flush_en    = rdy_in && flush_signal;
        commit_live = commit_en && is_writable(RF_update_reg);
        rename_live = rdy_in && rename_en && is_writable(rename_reg) && !flush_signal;
    end

    // Next-state: commit writes the value and may retire the rename, flush
    // then wipes all busy bits, otherwise a rename claims the destination.
    always_comb begin
        value_d = value_q;
        busy_d  = busy_q;
        tag_d   = tag_q;

        if (commit_live) begin
            value_d[RF_update_reg] = RF_update_data;
            // Only the youngest writer clears busy; a stale commit leaves the
            // newer rename in place.
            if (busy_q[RF_update_reg] && (tag_q[RF_update_reg] == RF_update_index)) begin
                busy_d[RF_update_reg] = 1'b0;
            end
        end

        if (flush_en) begin
            busy_d = '0;
        end

        // Applied after the commit so a same-cycle rename of the committing
        // register keeps it busy under the new tag.
        if (rename_live) begin
            busy_d[rename_reg] = 1'b1;
            tag_d[rename_reg]  = rename_index;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            // NOTE: the whole array is reset because a freshly reset core
            // must read every architectural register as a non-busy zero.
            value_q <= '0;
            busy_q  <= '0;
            tag_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples its _d
            // value from before this edge, independent of statement order.
            value_q <= value_d;
            busy_q  <= busy_d;
            tag_q   <= tag_d;
        end
    end

    // Read port for source operand 1.
    rf_read_port #(
        .RoB_WIDTH (RoB_WIDTH),
        .REG_COUNT (REG_COUNT)
    ) u_rs1_port (
        .rs_reg       (rs1_reg),
        .busy_q       (busy_q),
        .tag_q        (tag_q),
        .value_q      (value_q),
        .commit_en    (commit_en),
        .commit_reg   (RF_update_reg),
        .commit_index (RF_update_index),
        .commit_data  (RF_update_data),
        .flush_en     (flush_en),
        .rs_busy      (rs1_busy),
        .rs_tag       (rs1_tag),
        .rs_value     (rs1_value)
    );

    // Read port for source operand 2.
    rf_read_port #(
        .RoB_WIDTH (RoB_WIDTH),
        .REG_COUNT (REG_COUNT)
    ) u_rs2_port (
        .rs_reg       (rs2_reg),
        .busy_q       (busy_q),
        .tag_q        (tag_q),
        .value_q      (value_q),
        .commit_en    (commit_en),
        .commit_reg   (RF_update_reg),
        .commit_index (RF_update_index),
        .commit_data  (RF_update_data),
        .flush_en     (flush_en),
        .rs_busy      (rs2_busy),
        .rs_tag       (rs2_tag),
        .rs_value     (rs2_value)
    );

endmodule : register_file

// File: doc/register_file.md
# register_file

Architectural register file with per-register rename state, sitting between the RoB commit port and the Dispatcher. It holds the 32 committed RV32I register values plus a busy bit and RoB tag for each register. The Dispatcher reads operands and renames destinations through it. The RoB retires results into it. A RoB flush drops all rename state while keeping the committed values.

## Interface
Parameters:
- RoB_WIDTH, 3, RoB index width; must match the RoB.
- REG_COUNT, 32, number of architectural registers; fixed at 32.

Ports:
- clk_in  input  1  clock; all state updates on the rising edge.
- rst_in  input  1  reset, asynchronous, active-low.
- rdy_in  input  1  global ready; when low, all state holds.
- rs1_reg  input  5  Dispatcher source register 1.
- rs1_busy  output  1  rs1 awaits a RoB result.
- rs1_tag  output  RoB_WIDTH  RoB entry that will produce rs1; valid only when rs1_busy=1.
- rs1_value  output  32  rs1 committed value; valid only when rs1_busy=0.
- rs2_reg, rs2_busy, rs2_tag, rs2_value: same definitions as rs1, for source register 2.
- rename_en  input  1  Dispatcher allocates a RoB entry with a destination register.
- rename_reg  input  5  destination register.
- rename_index  input  RoB_WIDTH  allocated RoB index, taken from the RoB's new_entry_index.
- RF_update_en  input  1  RoB commit strobe.
- RF_update_reg  input  5  committed destination register.
- RF_update_index  input  RoB_WIDTH  RoB index of the committing entry.
- RF_update_data  input  32  committed value.
- flush_signal  input  1  RoB misprediction flush.

## Operation
- State per register i: value[i] (32 bits), busy[i] (1 bit), tag[i] (RoB_WIDTH bits).
- Reset (rst_in=0, asynchronous): every value=0, busy=0, tag=0. The read outputs are combinational, so they follow this state immediately.
- x0:
  - Reads of register 0 always return busy=0, tag=0, value=0.
  - Renames and commits targeting register 0 are ignored.
- Priority when rdy_in=1, highest first:
  - flush_signal=1: clear busy for all registers. If RF_update_en=1 in the same cycle, the commit value is still written. Any rename in that cycle is discarded.
  - Otherwise commit (RF_update_en=1, RF_update_reg=r≠0):
    - value[r] ← RF_update_data.
    - If busy[r]=1 and tag[r]=RF_update_index, clear busy[r].
    - Otherwise busy[r] and tag[r] are unchanged, because a younger in-flight writer exists.
  - Rename (rename_en=1, rename_reg=r≠0): busy[r] ← 1 and tag[r] ← rename_index. This is applied after the commit rule, so a same-cycle rename of the committing register leaves busy=1 with the new tag while the value still updates.
- rdy_in=0: no state changes; inputs are ignored. Read outputs remain combinational over the held state.
- Read forwarding (combinational), for each source port whose register s≠0:
  - Commit bypass: if RF_update_en=1, RF_update_reg=s, busy[s]=1 and tag[s]=RF_update_index, the port returns busy=0 and value=RF_update_data.
  - Flush: if flush_signal=1, the port returns busy=0 and value=value[s], or the bypassed data when the commit bypass also applies.
  - Otherwise the port returns the stored value, busy and tag.
  - Reads never see a same-cycle rename. The Dispatcher resolves intra-instruction rd==rs itself.

## Timing
- Reads: zero latency, purely combinational from rs*_reg and the current state plus the bypass terms.
- Rename and commit: take effect at the rising clk_in edge. A read in the next cycle observes them.
- Commit-to-consumer latency: 0 cycles through the bypass; 1 cycle through the stored state.
- Reset assertion mid-operation clears state immediately, independent of the clock. Deassertion is expected synchronous to clk_in, and the first update occurs at the first edge after deassertion.
- No back-pressure: every input strobe is accepted in the cycle it is presented (rdy_in=1).

## Structure
- Shared package:
  - RoB_WIDTH default.
  - REG_COUNT.
  - Register-0 constant.
- Sub-module rf_read_port: combinational forwarding logic covering the busy/tag/value mux, commit bypass and flush override. It is instantiated twice (rs1, rs2).
- Top level holds the three state arrays and the priority update logic.

## Test plan
- Reset then reads: pulse rst_in low without a clock edge, read rs1=5, rs2=0 -> both return busy=0, value=0.
- Rename then commit:
  - rename_en, reg=3, index=2 -> next cycle rs1=3 returns busy=1, tag=2.
  - RF_update_en, reg=3, index=2, data=0xDEADBEEF -> same cycle rs1=3 returns busy=0, value=0xDEADBEEF via bypass; next cycle the stored state gives the same result.
- Stale commit:
  - rename x7 to tag 1, then rename x7 to tag 4.
  - Commit reg=7, index=1, data=0x11 -> value[7]=0x11, busy stays 1, tag=4.
  - Commit index=4, data=0x22 -> busy=0, value=0x22.
- Same-cycle commit and rename: x9 busy with tag 0; commit reg=9, index=0, data=0x55 together with rename reg=9, index=3 -> next cycle busy=1, tag=3, value[9]=0x55.
- Flush:
  - Rename x1, x2, x31; assert flush_signal with rename_en reg=4 -> next cycle all four read busy=0 and values unchanged.
  - Commit during flush with reg=1, data=0x99 -> value[1]=0x99.
- x0 and rdy_in:
  - Rename and commit to reg 0 -> reads of 0 return busy=0, value=0.
  - With rdy_in=0, commit reg=6, data=0x77 -> value[6] unchanged.
